serial_cmd_scheduler: RTL and testbench
=======================================

SERIAL_CMD_SCHEDULER -- requirements
Module: serial_cmd_scheduler

Interface
REQ-001 Parameter EOF_BYTE, default 8'h0D, command terminator byte.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, maximum clk cycles allowed in WAIT_DECODE.
REQ-003 Parameter PENDING_WIDTH, default 4, width of the pending-command counter.
REQ-004 clk  in  1  single system clock; all logic on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 rx_byte_valid  in  1  one-cycle strobe; byte is pushed into the RX fifo this cycle.
REQ-007 rx_byte  in  8  byte being pushed.
REQ-008 fifo_empty  in  1  RX fifo empty flag.
REQ-009 fifo_data  in  8  fifo output byte, valid the cycle after fifo_pop.
REQ-010 fifo_pop  out  1  fifo pop strobe.
REQ-011 dec_read_clk  in  1  decoder pop request.
REQ-012 dec_cmd_ready  out  1  start request to decoder.
REQ-013 dec_cmd_processed  in  1  decoder done, held until acknowledged.
REQ-014 dec_decode_success  in  1  decoder result, valid while dec_cmd_processed=1.
REQ-015 dec_cmd_processed_received  out  1  acknowledge to decoder.
REQ-016 cmd_valid  out  1  one-cycle pulse, command decoded successfully.
REQ-017 cmd_error  out  1  one-cycle pulse, command failed (decode fail or timeout).
REQ-018 cmd_timeout  out  1  one-cycle pulse coincident with cmd_error when the cause is timeout.
REQ-019 cmd_count, err_count  out  16 each  wrapping counters of cmd_valid and cmd_error pulses.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 pending (PENDING_WIDTH bits) SHALL increment on rx_byte_valid with rx_byte==EOF_BYTE and decrement when a command is retired (REQ-027, REQ-029, REQ-030); simultaneous increment and decrement SHALL leave it unchanged; it SHALL saturate at all-ones and SHALL not decrement below 0.
REQ-022 States: IDLE, START, WAIT_DECODE, ACK, FLUSH_POP, FLUSH_CHK.
REQ-023 IDLE -> START when pending!=0 and fifo_empty==0.
REQ-024 START: dec_cmd_ready=1 for exactly one cycle, clear timeout counter and eof_seen flag -> WAIT_DECODE.
REQ-025 fifo_pop SHALL equal dec_read_clk in WAIT_DECODE, SHALL be 1 only in FLUSH_POP, and SHALL be 0 in all other states (combinational mux).
REQ-026 In WAIT_DECODE, on the cycle after each dec_read_clk pop, eof_seen SHALL be set if fifo_data==EOF_BYTE.
REQ-027 WAIT_DECODE with dec_cmd_processed=1: latch dec_decode_success -> ACK; timeout counter reaching TIMEOUT_CYCLES-1 first: pulse cmd_error and cmd_timeout, decrement pending if eof_seen, then IDLE if eof_seen, else FLUSH_POP.
REQ-028 ACK: dec_cmd_processed_received=1 until dec_cmd_processed=0, then deassert on the next cycle.
REQ-029 ACK exit on success: pulse cmd_valid, decrement pending -> IDLE.
REQ-030 ACK exit on failure: pulse cmd_error; if eof_seen, decrement pending -> IDLE; else -> FLUSH_POP.
REQ-031 FLUSH_POP: if fifo_empty -> IDLE with no pending change; else fifo_pop=1 -> FLUSH_CHK.
REQ-032 FLUSH_CHK: fifo_data==EOF_BYTE -> decrement pending -> IDLE; else -> FLUSH_POP (2 cycles per flushed byte).
REQ-033 At most one of cmd_valid/cmd_error SHALL pulse per command; cmd_count and err_count SHALL increment in the same cycle as their pulse and wrap 16'hFFFF -> 0.

Reset
REQ-034 rst=0 SHALL force IDLE asynchronously and clear pending, eof_seen, timeout counter, cmd_count and err_count; all outputs SHALL be 0.
REQ-035 Reset asserted mid-command SHALL abort without any cmd_valid/cmd_error pulse; the fifo is cleared externally by the same reset.

Verification
REQ-036 Push one valid command ending in 8'h0D; decoder success -> one dec_cmd_ready pulse, one cmd_valid, cmd_count=1, pending=0, busy=0.
REQ-037 Push two commands back-to-back -> two sequential decode cycles, cmd_count=2, no overlap of dec_cmd_ready.
REQ-038 Decoder fails after popping 3 of 8 bytes -> cmd_error, FLUSH pops the remaining 5 bytes up to EOF, err_count=1, next command decodes with cmd_valid.
REQ-039 Decoder never responds -> cmd_error and cmd_timeout after exactly TIMEOUT_CYCLES WAIT_DECODE cycles, followed by a flush to EOF.
REQ-040 EOF pushed in the same cycle as a command retires -> pending unchanged; reset pulse during WAIT_DECODE -> all outputs 0, no pulses.

Source files
------------

// File: rtl/serial_cmd_scheduler_if.sv
// Scheduler-side bundle: RX byte stream, RX fifo read port, decoder handshake and command status.
interface serial_cmd_scheduler_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic              rx_byte_valid;
  logic [BYTE_W-1:0] rx_byte;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_data;
  logic              fifo_pop;
  logic              dec_read_clk;
  logic              dec_cmd_ready;
  logic              dec_cmd_processed;
  logic              dec_decode_success;
  logic              dec_cmd_processed_received;
  logic              cmd_valid;
  logic              cmd_error;
  logic              cmd_timeout;
  logic [CNT_W-1:0]  cmd_count;
  logic [CNT_W-1:0]  err_count;
  logic              busy;

  modport master (
    input  rx_byte_valid, rx_byte, fifo_empty, fifo_data,
    input  dec_read_clk, dec_cmd_processed, dec_decode_success,
    output fifo_pop, dec_cmd_ready, dec_cmd_processed_received,
    output cmd_valid, cmd_error, cmd_timeout, cmd_count, err_count, busy
  );

  modport slave (
    output rx_byte_valid, rx_byte, fifo_empty, fifo_data,
    output dec_read_clk, dec_cmd_processed, dec_decode_success,
    input  fifo_pop, dec_cmd_ready, dec_cmd_processed_received,
    input  cmd_valid, cmd_error, cmd_timeout, cmd_count, err_count, busy
  );
endinterface

// File: rtl/serial_cmd_scheduler.sv
// Hands EOF-terminated commands from the RX fifo to a decoder one at a time,
// with a decode watchdog and a flush-to-EOF recovery path after failures.
module serial_cmd_scheduler #(
  parameter logic [7:0]  EOF_BYTE       = 8'h0D,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned PENDING_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_cmd_scheduler_if.master  bus
);

  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_DECODE, ACK, FLUSH_POP, FLUSH_CHK
  } state_t;

  state_t                   state;
  logic [PENDING_WIDTH-1:0] pending;
  logic [TCNT_W-1:0]        tcnt;
  logic                     eof_seen;
  logic                     pop_d;
  logic                     success_q;

  logic eof_in_c;
  logic eof_now_c;
  logic retire_c;

  assign eof_in_c  = bus.rx_byte_valid && (bus.rx_byte == EOF_BYTE);
  // Byte popped by the decoder last cycle is visible now; fold it in before deciding.
  assign eof_now_c = eof_seen || (pop_d && (bus.fifo_data == EOF_BYTE));

  // Fifo read port is owned by the decoder while decoding, by the flush path otherwise.
  always_comb begin
    bus.fifo_pop = 1'b0;
    case (state)
      WAIT_DECODE: bus.fifo_pop = bus.dec_read_clk;
      FLUSH_POP:   bus.fifo_pop = ~bus.fifo_empty;
      default:     bus.fifo_pop = 1'b0;
    endcase
  end

  // A command leaves the pending count once its EOF byte has left the fifo.
  always_comb begin
    retire_c = 1'b0;
    case (state)
      WAIT_DECODE: retire_c = !bus.dec_cmd_processed && (tcnt == TCNT_LAST) && eof_now_c;
      ACK:         retire_c = !bus.dec_cmd_processed && (success_q || eof_now_c);
      FLUSH_CHK:   retire_c = (bus.fifo_data == EOF_BYTE);
      default:     retire_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else if (eof_in_c && !retire_c) begin
      if (pending != '1) pending <= pending + PENDING_WIDTH'(1);
    end else if (!eof_in_c && retire_c) begin
      if (pending != '0) pending <= pending - PENDING_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                          <= IDLE;
      tcnt                           <= '0;
      eof_seen                       <= 1'b0;
      pop_d                          <= 1'b0;
      success_q                      <= 1'b0;
      bus.dec_cmd_ready              <= 1'b0;
      bus.dec_cmd_processed_received <= 1'b0;
      bus.cmd_valid                  <= 1'b0;
      bus.cmd_error                  <= 1'b0;
      bus.cmd_timeout                <= 1'b0;
      bus.cmd_count                  <= '0;
      bus.err_count                  <= '0;
      bus.busy                       <= 1'b0;
    end else begin
      bus.dec_cmd_ready <= 1'b0;
      bus.cmd_valid     <= 1'b0;
      bus.cmd_error     <= 1'b0;
      bus.cmd_timeout   <= 1'b0;
      pop_d             <= (state == WAIT_DECODE) && bus.dec_read_clk;
      if (pop_d && (bus.fifo_data == EOF_BYTE)) eof_seen <= 1'b1;

      case (state)
        IDLE: begin
          if ((pending != '0) && !bus.fifo_empty) begin
            state             <= START;
            bus.dec_cmd_ready <= 1'b1;
            bus.busy          <= 1'b1;
          end
        end
        START: begin
          tcnt     <= '0;
          eof_seen <= 1'b0;
          state    <= WAIT_DECODE;
        end
        WAIT_DECODE: begin
          if (bus.dec_cmd_processed) begin
            success_q                      <= bus.dec_decode_success;
            bus.dec_cmd_processed_received <= 1'b1;
            state                          <= ACK;
          end else if (tcnt == TCNT_LAST) begin
            bus.cmd_error   <= 1'b1;
            bus.cmd_timeout <= 1'b1;
            bus.err_count   <= bus.err_count + 16'd1;
            state           <= eof_now_c ? IDLE : FLUSH_POP;
            bus.busy        <= !eof_now_c;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        ACK: begin
          if (!bus.dec_cmd_processed) begin
            bus.dec_cmd_processed_received <= 1'b0;
            if (success_q) begin
              bus.cmd_valid <= 1'b1;
              bus.cmd_count <= bus.cmd_count + 16'd1;
              state         <= IDLE;
              bus.busy      <= 1'b0;
            end else begin
              bus.cmd_error <= 1'b1;
              bus.err_count <= bus.err_count + 16'd1;
              state         <= eof_now_c ? IDLE : FLUSH_POP;
              bus.busy      <= !eof_now_c;
            end
          end
        end
        FLUSH_POP: begin
          if (bus.fifo_empty) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            state <= FLUSH_CHK;
          end
        end
        FLUSH_CHK: begin
          if (bus.fifo_data == EOF_BYTE) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            state <= FLUSH_POP;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmd_scheduler.sv
// Scoreboard bench for serial_cmd_scheduler: behavioural RX fifo and decoder,
// expected status pulses queued at stimulus time and checked by a monitor.
module tb_serial_cmd_scheduler;
  localparam int unsigned T   = 40;
  localparam logic [7:0]  EOF = 8'h0D;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_cmd_scheduler_if ifc();

  serial_cmd_scheduler #(
    .EOF_BYTE(EOF), .TIMEOUT_CYCLES(T), .PENDING_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(ifc.master)
  );

  typedef struct {
    bit          valid;
    bit          error;
    bit          timeout;
    logic [15:0] cc;
    logic [15:0] ec;
  } exp_t;

  typedef struct {
    int mode;   // 0 success, 1 fail, 2 never responds
    int pops;
  } dcfg_t;

  exp_t        sb[$];
  dcfg_t       dq[$];
  logic [7:0]  fq[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ready_cyc = 0;
  int          ready_cnt = 0;
  int          exp_ready = 0;
  logic [15:0] exp_cc = '0;
  logic [15:0] exp_ec = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RX fifo model: push on rx_byte_valid, data registered one cycle after pop.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fq.delete();
      ifc.fifo_data  <= 8'h00;
      ifc.fifo_empty <= 1'b1;
    end else begin
      if (ifc.fifo_pop) begin
        if (fq.size() > 0) ifc.fifo_data <= fq.pop_front();
        else begin
          n_vec++; n_fail++;
          $display("FAIL pop_on_empty: got pop expected none (t=%0t)", $time);
        end
      end
      if (ifc.rx_byte_valid) fq.push_back(ifc.rx_byte);
      ifc.fifo_empty <= (fq.size() == 0);
    end
  end

  // Decoder model driven by a per-command config queue.
  initial begin
    dcfg_t      c;
    logic [7:0] last;
    int         k;
    ifc.dec_read_clk       = 1'b0;
    ifc.dec_cmd_processed  = 1'b0;
    ifc.dec_decode_success = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && ifc.dec_cmd_ready) begin
        ready_cnt++;
        ready_cyc = cyc;
        last = 8'h00;
        if (dq.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_ready: got dec_cmd_ready expected none (t=%0t)", $time);
          c = '{2, 0};
        end else c = dq.pop_front();
        for (int i = 0; i < c.pops; i++) begin
          @(posedge clk); #1 ifc.dec_read_clk = 1'b1;
          @(posedge clk); #1 ifc.dec_read_clk = 1'b0;
          last = ifc.fifo_data;
        end
        if (c.mode == 0) check("dec_last_byte", 32'(last), 32'(EOF));
        if (c.mode != 2) begin
          @(posedge clk); #1;
          ifc.dec_cmd_processed  = 1'b1;
          ifc.dec_decode_success = (c.mode == 0);
          k = 0;
          while (!ifc.dec_cmd_processed_received && k < 50) begin
            @(posedge clk); #1;
            k++;
          end
          check("ack_received", 32'(ifc.dec_cmd_processed_received), 32'd1);
          ifc.dec_cmd_processed  = 1'b0;
          ifc.dec_decode_success = 1'b0;
        end
      end
    end
  end

  // Monitor: every status pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (ifc.cmd_valid || ifc.cmd_error)) begin
      if (sb.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_pulse: got valid=%0b error=%0b expected none (t=%0t)",
                 ifc.cmd_valid, ifc.cmd_error, $time);
      end else begin
        e = sb.pop_front();
        check("cmd_valid", 32'(ifc.cmd_valid), 32'(e.valid));
        check("cmd_error", 32'(ifc.cmd_error), 32'(e.error));
        check("cmd_timeout", 32'(ifc.cmd_timeout), 32'(e.timeout));
        check("cmd_count", 32'(ifc.cmd_count), 32'(e.cc));
        check("err_count", 32'(ifc.err_count), 32'(e.ec));
        if (e.timeout) check("timeout_latency", 32'(cyc - ready_cyc), 32'(T + 1));
      end
    end
  end

  task automatic expect_cmd(input int mode, input int pops, input bit is_timeout);
    exp_t e;
    dq.push_back('{mode, pops});
    exp_ready++;
    if (mode == 0) exp_cc = exp_cc + 16'd1;
    else           exp_ec = exp_ec + 16'd1;
    e = '{(mode == 0), (mode != 0), is_timeout, exp_cc, exp_ec};
    sb.push_back(e);
  endtask

  task automatic push_raw(input logic [7:0] b);
    @(posedge clk); #1;
    ifc.rx_byte_valid = 1'b1;
    ifc.rx_byte       = b;
  endtask

  task automatic push_cmd(input int n, input logic [7:0] seed);
    for (int i = 0; i < n; i++) push_raw((i == n - 1) ? EOF : seed + 8'(i));
  endtask

  task automatic rx_idle();
    @(posedge clk); #1;
    ifc.rx_byte_valid = 1'b0;
    ifc.rx_byte       = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(sb.size() == 0 && dq.size() == 0 && !ifc.busy) && k < 2000);
    check({tag, "_done_in_time"}, 32'(k < 2000), 32'd1);
    repeat (2) @(negedge clk);
    check({tag, "_busy"}, 32'(ifc.busy), 32'd0);
    check({tag, "_fifo_drained"}, 32'(fq.size()), 32'd0);
    check({tag, "_ready_pulses"}, 32'(ready_cnt), 32'(exp_ready));
    check({tag, "_cmd_count"}, 32'(ifc.cmd_count), 32'(exp_cc));
    check({tag, "_err_count"}, 32'(ifc.err_count), 32'(exp_ec));
    check({tag, "_timeout_low"}, 32'(ifc.cmd_timeout), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(ifc.busy), 32'd0);
    check({tag, "_ready"}, 32'(ifc.dec_cmd_ready), 32'd0);
    check({tag, "_ack"}, 32'(ifc.dec_cmd_processed_received), 32'd0);
    check({tag, "_valid"}, 32'(ifc.cmd_valid), 32'd0);
    check({tag, "_error"}, 32'(ifc.cmd_error), 32'd0);
    check({tag, "_timeout"}, 32'(ifc.cmd_timeout), 32'd0);
    check({tag, "_cmd_count"}, 32'(ifc.cmd_count), 32'd0);
    check({tag, "_err_count"}, 32'(ifc.err_count), 32'd0);
    check({tag, "_fifo_pop"}, 32'(ifc.fifo_pop), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int r0;
    ifc.rx_byte_valid = 1'b0;
    ifc.rx_byte       = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b1;

    // Single successful command.
    expect_cmd(0, 5, 1'b0);
    push_cmd(5, 8'h41);
    rx_idle();
    wait_idle("single");

    // Two commands back to back.
    expect_cmd(0, 4, 1'b0);
    expect_cmd(0, 3, 1'b0);
    push_cmd(4, 8'h50);
    push_cmd(3, 8'h58);
    rx_idle();
    wait_idle("b2b");

    // Decode failure after 3 of 8 bytes, flush, then a good command.
    expect_cmd(1, 3, 1'b0);
    expect_cmd(0, 3, 1'b0);
    push_cmd(8, 8'h20);
    push_cmd(3, 8'h30);
    rx_idle();
    wait_idle("fail_flush");

    // Decoder never answers: watchdog, flush, then a good command.
    expect_cmd(2, 2, 1'b1);
    expect_cmd(0, 2, 1'b0);
    push_cmd(6, 8'h70);
    push_cmd(2, 8'h78);
    rx_idle();
    wait_idle("timeout");

    // EOF arrives in the very cycle the previous command retires.
    expect_cmd(0, 4, 1'b0);
    expect_cmd(0, 3, 1'b0);
    push_cmd(4, 8'h61);
    push_raw(8'h66);
    push_raw(8'h67);
    rx_idle();
    k = 0;
    do begin
      @(posedge clk); #2;
      k++;
    end while (!ifc.dec_cmd_processed_received && k < 200);
    check("coincide_ack_seen", 32'(ifc.dec_cmd_processed_received), 32'd1);
    ifc.rx_byte_valid = 1'b1;
    ifc.rx_byte       = EOF;
    @(posedge clk); #1;
    ifc.rx_byte_valid = 1'b0;
    ifc.rx_byte       = 8'h00;
    wait_idle("coincide");

    // Reset in the middle of WAIT_DECODE aborts silently.
    dq.push_back('{2, 1});
    exp_ready++;
    r0 = ready_cnt;
    push_cmd(5, 8'h11);
    rx_idle();
    k = 0;
    while (ready_cnt == r0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("abort_started", 32'(ready_cnt - r0), 32'd1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_all_zero("abort");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_cc = '0;
    exp_ec = '0;
    expect_cmd(0, 3, 1'b0);
    push_cmd(3, 8'h01);
    rx_idle();
    wait_idle("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
